// File: rtl/icache_assoc_if.sv
// Fetch handshake and AXI4 read channel of the instruction cache.
// master: the cache side; slave: the fetch stage and the interconnect.
interface icache_assoc_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        flush;
  logic        flush_busy;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    input  req_valid, req_pc, flush,
    output req_ready, resp_valid, resp_inst, resp_err, flush_busy,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    output req_valid, req_pc, flush,
    input  req_ready, resp_valid, resp_inst, resp_err, flush_busy,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: AXI4 INCR line refill,
// per-set round-robin replacement, whole-cache flush.
module icache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          resetn,
  icache_assoc_if.master bus
);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int OFF_W = WRD_W + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS, REFILL, RESP, FLUSH
  } state_t;

  state_t           state;
  logic [31:2]      req_q;
  logic [SETS-1:0]  valid_q [WAYS];
  logic [TAG_W-1:0] tag_q [WAYS][SETS];
  logic [31:0]      data_q [WAYS][SETS][LINE_WORDS];
  logic [WAY_W-1:0] rr_q [SETS];
  logic [WAY_W-1:0] victim_q;
  logic [WRD_W-1:0] beat_cnt;
  logic             err_q;
  logic             flush_pend;
  logic [IDX_W-1:0] fl_idx;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WRD_W-1:0] word;
  logic             hit;
  logic             has_free;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] rd_way;
  logic [WAY_W-1:0] rr_next;
  logic             beat_err;
  logic             last_beat;
  logic             fill_err;
  logic             unused;

  assign tag  = req_q[31:IDX_W+OFF_W];
  assign idx  = req_q[IDX_W+OFF_W-1:OFF_W];
  assign word = req_q[OFF_W-1:2];

  // descending scan so the lowest-numbered way wins
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign rr_next = (rr_q[idx] == WAY_W'(WAYS - 1)) ?
                   '0 : rr_q[idx] + 1'b1;
  assign beat_err  = bus.RRESP != 2'b00;
  assign last_beat = bus.RVALID &&
                     beat_cnt == WRD_W'(LINE_WORDS - 1);
  assign fill_err  = err_q | beat_err;
  assign rd_way    = (state == RESP) ? victim_q : hit_way;

  assign bus.req_ready  = !flush_pend &&
                          (state == IDLE ||
                           (state == LOOKUP && hit));
  assign bus.resp_valid = (state == LOOKUP && hit) ||
                          state == RESP;
  assign bus.resp_err   = state == RESP && err_q;
  assign bus.resp_inst  = data_q[rd_way][idx][word];
  assign bus.flush_busy = flush_pend || state == FLUSH;
  assign bus.ARVALID    = state == MISS;
  assign bus.ARADDR     = {req_q[31:OFF_W], {OFF_W{1'b0}}};
  assign bus.ARLEN      = 8'(LINE_WORDS - 1);
  assign bus.ARSIZE     = 3'b010;
  assign bus.ARBURST    = 2'b01;
  assign bus.RREADY     = state == REFILL;

  // beat count alone terminates the burst
  assign unused = ^{bus.RLAST, bus.req_pc[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      req_q      <= '0;
      victim_q   <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
      flush_pend <= 1'b0;
      fl_idx     <= '0;
      for (int w = 0; w < WAYS; w++)
        valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++)
        rr_q[s] <= '0;
    end else begin
      if (bus.flush)
        flush_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (flush_pend) begin
            state      <= FLUSH;
            flush_pend <= bus.flush;
            fl_idx     <= '0;
          end else if (bus.req_valid) begin
            req_q <= bus.req_pc[31:2];
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (flush_pend) begin
              state      <= FLUSH;
              flush_pend <= bus.flush;
              fl_idx     <= '0;
            end else if (bus.req_valid) begin
              req_q <= bus.req_pc[31:2];
            end else begin
              state <= IDLE;
            end
          end else begin
            victim_q <= has_free ? free_way : rr_q[idx];
            state    <= MISS;
          end
        end
        MISS: begin
          if (bus.ARREADY) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (bus.RVALID) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_err)
              err_q <= 1'b1;
            if (last_beat) begin
              valid_q[victim_q][idx] <= !fill_err;
              rr_q[idx] <= rr_next;
              state     <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        FLUSH: begin
          for (int w = 0; w < WAYS; w++)
            valid_q[w][fl_idx] <= 1'b0;
          rr_q[fl_idx] <= '0;
          fl_idx <= fl_idx + 1'b1;
          if (fl_idx == IDX_W'(SETS - 1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && bus.RVALID) begin
      data_q[victim_q][idx][beat_cnt] <= bus.RDATA;
      if (last_beat)
        tag_q[victim_q][idx] <= tag;
    end
  end
endmodule
